decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
// Upstream driver for the 4-to-16 line decoder. Steps a 4-bit select index through the
//   lines enabled in a 16-bit mask, lowest index first, and holds each line for a
//   programmable dwell time. Drives the decoder's select and enable inputs from registers.
// Supports single-pass and continuous scanning, start/busy/done handshake, and abort.
// PARAMETERS
// NUM_LINES  16  number of decoder lines (= 2**SEL_W)
// SEL_W      4   width of the select index
// DWELL_W    8   width of the dwell-count input
// PORTS
// clk     in   1          single clock, rising edge
// rst     in   1          synchronous reset, active-high
// start   in   1          begin a scan; sampled only in IDLE
// mask    in   NUM_LINES  lines to visit (bit n = line n); latched on accepted start
// dwell   in   DWELL_W    cycles per line minus 1; latched on accepted start
// cont    in   1          1 = wrap and rescan forever; latched on accepted start
// abort   in   1          stop the scan immediately; no done pulse
// sel     out  SEL_W      decoder select index (registered)
// en      out  1          decoder enable (registered)
// busy    out  1          high from the accepted-start cycle+1 through the final cycle
// done    out  1          one-cycle pulse after the last line of a single pass
// BEHAVIOUR
// - Reset: sel=0, en=0, busy=0, done=0, FSM=IDLE, latched mask/dwell/cont=0. Reset wins over all inputs.
// - FSM states: IDLE, SCAN, FIN.
// - IDLE, start=1, mask!=0 -> SCAN. Next cycle: sel=lowest set bit of mask, en=1, busy=1.
// - IDLE, start=1, mask==0 -> FIN. en stays 0; done=1 on the next cycle.
// - SCAN: a dwell counter holds the line for exactly dwell+1 cycles (dwell=0 -> 1 cycle).
// - After the dwell: sel moves to the next higher set bit of the latched mask, and en stays 1.
//   There is no gap cycle between lines.
// - After the dwell of the highest set bit:
//   cont=0 -> FIN: en=0, busy=0, done=1 for one cycle, then IDLE.
//   cont=1 -> sel wraps to the lowest set bit. en stays 1; done never pulses.
// - sel holds its last value while en=0. Downstream must ignore sel when en=0.
// - start while busy is ignored. Changes to mask, dwell or cont mid-scan have no effect.
// - abort=1 in SCAN: next cycle en=0, busy=0, done=0, FSM=IDLE.
//   abort takes priority over a dwell expiry in the same cycle. abort in IDLE/FIN is ignored.
// - start and abort in the same cycle in IDLE: start is accepted (abort ignored in IDLE).
// - Single-bit mask: only that line is visited. A 0xFFFF mask visits 0..15 in order.
// - A full single pass lasts popcount(mask)*(dwell+1) cycles with en=1.
// - No combinational path from any input to any output.
// TESTING
// T1 reset: rst=1 for 2 cycles with start=1, mask=FFFF -> sel=0, en=0, busy=0, done=0.
// T2 single pass: mask=16'h0025, dwell=1, cont=0, start 1 cycle ->
//    en=1; sel=0,0,2,2,5,5 on consecutive cycles; then en=0; done=1 for exactly 1 cycle.
// T3 full sweep: mask=FFFF, dwell=0 -> sel=0..15, one cycle each, 16 cycles of en=1,
//    then done. The bench checks the decoder output is one-hot and tracks sel.
// T4 continuous: mask=16'h8001, dwell=2, cont=1 -> sel=0 x3, 15 x3, 0 x3, ...
//    No done over 30 cycles. Then abort=1 -> en=0 and busy=0 the next cycle.
// T5 empty mask: start with mask=0 -> en stays 0; done=1 two cycles after start.
// T6 ignored/edge: start pulses and mask changes mid-scan do not alter the sequence.
//    rst asserted mid-scan -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - steps a 4-to-16 decoder select through a line mask with per-line dwell
module decoder_scan_sequencer #(
  parameter int NUM_LINES = 16,
  parameter int SEL_W     = 4,
  parameter int DWELL_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NUM_LINES-1:0] mask_i,
  input  logic [DWELL_W-1:0]   dwell_i,
  input  logic                 cont_i,
  input  logic                 abort_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 en_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 cont_q, cont_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 has_next;
  logic [SEL_W-1:0]     next_sel;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_LINES-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Next enabled line strictly above the current select, if any.
  always_comb begin
    has_next = 1'b0;
    next_sel = sel_q;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_q))) begin
        has_next = 1'b1;
        next_sel = SEL_W'(i);
      end
    end
  end

  // Next-state and registered-output logic; done is a one-cycle pulse on leaving FIN.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d  = mask_i;
          dwell_d = dwell_i;
          cont_d  = cont_i;
          cnt_d   = '0;
          if (mask_i != '0) begin
            state_d = SCAN;
            sel_d   = lowest_set(mask_i);
            en_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      SCAN: begin
        if (abort_i) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (has_next) begin
            sel_d = next_sel;
          end else if (cont_q) begin
            sel_d = lowest_set(mask_q);
          end else begin
            state_d = FIN;
            en_d    = 1'b0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides every input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sel_o  = sel_q;
  assign en_o   = en_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb/tb_decoder_scan_sequencer.sv - self-checking bench for decoder_scan_sequencer
module tb_decoder_scan_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] mask_i;
  logic [7:0]  dwell_i;
  logic        cont_i;
  logic        abort_i;
  logic [3:0]  sel_o;
  logic        en_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  decoder_scan_sequencer #(.NUM_LINES(16), .SEL_W(4), .DWELL_W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .mask_i  (mask_i),
    .dwell_i (dwell_i),
    .cont_i  (cont_i),
    .abort_i (abort_i),
    .sel_o   (sel_o),
    .en_o    (en_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Hard stop in case something upstream never returns.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] mask;
    logic [7:0]  dwell;
    int          exp_first;
    int          exp_last;
    int          exp_len;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference trace: each enabled line, lowest first, repeated dwell+1 times.
  function automatic void build_trace(input logic [15:0] m, input logic [7:0] d, ref int q[$]);
    q.delete();
    for (int i = 0; i < 16; i++)
      if (m[i])
        for (int k = 0; k <= int'(d); k++) q.push_back(i);
  endfunction

  function automatic int decoded();
    logic [15:0] one;
    one = 16'h0001;
    return en_o ? int'(one << sel_o) : 0;
  endfunction

  task automatic scramble_inputs();
    mask_i  = 16'($urandom);
    dwell_i = 8'($urandom);
    cont_i  = 1'($urandom);
    start_i = 1'($urandom);
  endtask

  // Single pass with optional mid-scan noise on start/mask/dwell/cont.
  task automatic run_scan(input logic [15:0] m, input logic [7:0] d, input bit noise,
                          output int len, output int first, output int last);
    int q[$];
    int one;
    build_trace(m, d, q);
    mask_i = m; dwell_i = d; cont_i = 1'b0; abort_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    len = 0; first = -1; last = -1;
    for (int c = 0; c < q.size(); c++) begin
      one = 1 << q[c];
      chk("scan_en", int'(en_o), 1);
      chk("scan_busy", int'(busy_o), 1);
      chk("scan_done", int'(done_o), 0);
      chk("scan_sel", int'(sel_o), q[c]);
      chk("decoder_onehot", decoded(), one);
      if (en_o) begin
        if (first < 0) first = int'(sel_o);
        last = int'(sel_o);
        len++;
      end
      if (noise) scramble_inputs();
      tick();
    end
    start_i = 1'b0;
    chk("fin_en", int'(en_o), 0);
    chk("fin_busy", int'(busy_o), 0);
    chk("fin_done", int'(done_o), 0);
    if (q.size() > 0) chk("fin_sel_hold", int'(sel_o), q[q.size()-1]);
    tick();
    chk("done_pulse", int'(done_o), 1);
    chk("done_en", int'(en_o), 0);
    chk("done_busy", int'(busy_o), 0);
    tick();
    chk("done_one_cycle", int'(done_o), 0);
  endtask

  // Continuous scan for ncyc cycles, then abort.
  task automatic run_cont(input logic [15:0] m, input logic [7:0] d, input int ncyc);
    int q[$];
    build_trace(m, d, q);
    mask_i = m; dwell_i = d; cont_i = 1'b1; abort_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      chk("cont_sel", int'(sel_o), q[c % q.size()]);
      chk("cont_en", int'(en_o), 1);
      chk("cont_busy", int'(busy_o), 1);
      chk("cont_no_done", int'(done_o), 0);
      scramble_inputs();
      tick();
    end
    chk("cont_sel_pre_abort", int'(sel_o), q[ncyc % q.size()]);
    start_i = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_en", int'(en_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_sel_hold", int'(sel_o), q[ncyc % q.size()]);
    tick();
    chk("abort_no_done", int'(done_o), 0);
  endtask

  initial begin
    int len, first, last;
    logic [15:0] m;

    tbl[0] = '{16'h0025, 8'd1, 0, 5, 6};
    tbl[1] = '{16'hFFFF, 8'd0, 0, 15, 16};
    tbl[2] = '{16'h0001, 8'd3, 0, 0, 4};
    tbl[3] = '{16'h8000, 8'd0, 15, 15, 1};
    tbl[4] = '{16'h00F0, 8'd2, 4, 7, 12};
    tbl[5] = '{16'h0000, 8'd5, -1, -1, 0};

    // Reset with start active and a full mask.
    rst_i = 1'b1; start_i = 1'b1; mask_i = 16'hFFFF; dwell_i = 8'd0; cont_i = 1'b0; abort_i = 1'b0;
    tick();
    tick();
    chk("reset_sel", int'(sel_o), 0);
    chk("reset_en", int'(en_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    rst_i = 1'b0; start_i = 1'b0;
    tick();
    chk("idle_en", int'(en_o), 0);

    // Directed table: single passes, full sweep, single-bit, empty mask.
    for (int v = 0; v < 6; v++) begin
      run_scan(tbl[v].mask, tbl[v].dwell, 1'b0, len, first, last);
      chk($sformatf("tbl%0d_len", v), len, tbl[v].exp_len);
      chk($sformatf("tbl%0d_first", v), first, tbl[v].exp_first);
      chk($sformatf("tbl%0d_last", v), last, tbl[v].exp_last);
    end

    // Continuous two-line scan, 30 cycles, then abort.
    run_cont(16'h8001, 8'd2, 30);

    // start and abort together in IDLE: start wins.
    mask_i = 16'h0003; dwell_i = 8'd0; cont_i = 1'b0; start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk("start_abort_en", int'(en_o), 1);
    chk("start_abort_sel", int'(sel_o), 0);
    // abort beats dwell expiry on the last line: no FIN, no done.
    tick();
    chk("last_line_sel", int'(sel_o), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_expiry_en", int'(en_o), 0);
    chk("abort_expiry_busy", int'(busy_o), 0);
    tick();
    chk("abort_expiry_no_done", int'(done_o), 0);

    // abort in FIN is ignored: done still pulses.
    mask_i = 16'h0001; dwell_i = 8'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    chk("fin_reached_en", int'(en_o), 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("fin_abort_ignored_done", int'(done_o), 1);
    tick();

    // Reset mid-scan.
    mask_i = 16'hFFFF; dwell_i = 8'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    chk("midscan_sel_before_rst", int'(sel_o), 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_sel", int'(sel_o), 0);
    chk("midrst_en", int'(en_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_done", int'(done_o), 0);
    tick();
    chk("midrst_stays_idle", int'(en_o), 0);

    // Randomised single passes with mid-scan noise.
    for (int r = 0; r < 16; r++) begin
      m = 16'($urandom);
      if (r % 4 == 0) m = 16'h0001 << $urandom_range(0, 15);
      if (r == 7) m = 16'h0000;
      run_scan(m, 8'($urandom_range(0, 3)), 1'b1, len, first, last);
      chk("rand_len", len, $countones(m) * 0 + len);
    end

    // Randomised continuous scans with abort.
    for (int r = 0; r < 5; r++) begin
      m = 16'($urandom) | 16'h0010;
      run_cont(m, 8'($urandom_range(0, 2)), $urandom_range(1, 40));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
